bch_dec_rd_corr: RTL and testbench

Read-path correction stage that sits directly downstream of the BCH decoder. Accepts raw read words with stored ECC through a valid/ready handshake and registers them. Runs them through the universal BCH decoder, applies the returned error mask, and delivers corrected data with error status. Keeps saturating correction statistics and, when configured, issues scrub write-back requests for corrected words.

---
 rtl/bch_dec_pkg.sv | 45 ++++
 rtl/bch_dec_dcd_univ_top.sv | 49 ++++
 rtl/bch_dec_rd_corr.sv | 165 ++++++++++++++++
 tb/tb_bch_dec_rd_corr.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bch_dec_pkg
// Description : Shared definitions for the BCH read-path decoder blocks.
//               ecc_width() gives the check width of the single-error-
//               correcting / double-error-detecting code used by the
//               decoder (Hamming syndrome bits plus one overall parity
//               bit). data_pos() maps a data bit index to its codeword
//               position, which is its syndrome signature; positions that
//               are powers of two belong to the check bits. SAT_ALL_ONES
//               is the saturation pattern for statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef ECC_WORD_SIZE
`define ECC_WORD_SIZE 32
`endif

package bch_dec_pkg;

  localparam logic [63:0] SAT_ALL_ONES = '1;

  // Smallest m with 2^m >= dw + m + 1, plus one overall parity bit.
  function automatic int ecc_width(input int dw);
    int m;
    m = 0;
    for (int k = 1; k < 31; k++) begin
      if (m == 0 && (1 << k) >= dw + k + 1) m = k;
    end
    return m + 1;
  endfunction

  // Data bit i sits at the i-th codeword position (from 3 upward) that is
  // not a power of two. Walking the powers in ascending order and bumping
  // the position past each one reached gives that index directly.
  function automatic int data_pos(input int i);
    int p;
    p = i + 3;
    for (int k = 2; k < 31; k++) begin
      if ((1 << k) <= p) p = p + 1;
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bch_dec_dcd_univ_top.sv
`default_nettype none
// ============================================================================
// Module      : bch_dec_dcd_univ_top
// Description : Combinational SEC-DED decoder.
//               Ports: d/ecc (received word), msk (data bits to flip),
//               err_det (data needs correction or cannot be corrected).
//               ecc[E_WIDTH-2:0] hold the syndrome check bits,
//               ecc[E_WIDTH-1] holds even parity over data and all checks.
//               A single error confined to a check bit leaves the data
//               intact, so it is reported as clean (err_det = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module bch_dec_dcd_univ_top
  import bch_dec_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int E_WIDTH = ecc_width(D_WIDTH)
) (
  input  logic [D_WIDTH-1:0] d,
  input  logic [E_WIDTH-1:0] ecc,
  output logic [D_WIDTH-1:0] msk,
  output logic               err_det
);

  localparam int M = E_WIDTH - 1;

  logic [M-1:0] syn;
  logic         par;
  logic         syn_pow2;

  always_comb begin
    syn = ecc[M-1:0];
    for (int i = 0; i < D_WIDTH; i++) begin
      if (d[i]) syn = syn ^ M'(data_pos(i));
    end
    par      = ^{d, ecc};
    syn_pow2 = ((syn & (syn - M'(1))) == '0);
    // Odd parity with a syndrome naming a data position is a single
    // data-bit error; anything else with a nonzero syndrome besides a lone
    // check-bit flip is uncorrectable and leaves the mask empty.
    msk = '0;
    for (int i = 0; i < D_WIDTH; i++) begin
      if (par && (syn == M'(data_pos(i)))) msk[i] = 1'b1;
    end
    err_det = (syn != '0) && !(par && syn_pow2);
  end

endmodule
`default_nettype wire

// File: rtl/bch_dec_rd_corr.sv
`default_nettype none
// ============================================================================
// Module      : bch_dec_rd_corr
// Description : Two-stage read-path correction stage. S1 registers the raw
//               word, the decoder runs on S1, S2 registers corrected data
//               and status. Saturating correction statistics; optional
//               scrub write-back request port (macro BCH_DEC_SCRUB_EN).
// Ports       : in_*  - valid/ready input (raw data, stored ECC, addr tag)
//               out_* - valid/ready output (corrected data, tag, status)
//               cnt_clr, corr_cnt, uncorr_cnt - statistics
//               scrub_* - scrub request (only with BCH_DEC_SCRUB_EN)
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef ECC_WORD_SIZE
`define ECC_WORD_SIZE 32
`endif

module bch_dec_rd_corr
  import bch_dec_pkg::*;
#(
  parameter int P_D_WIDTH   = `ECC_WORD_SIZE,
  parameter int P_E_WIDTH   = bch_dec_pkg::ecc_width(P_D_WIDTH),
  parameter int P_A_WIDTH   = 16,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [P_D_WIDTH-1:0]   in_d,
  input  logic [P_E_WIDTH-1:0]   in_ecc,
  input  logic [P_A_WIDTH-1:0]   in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_D_WIDTH-1:0]   out_d,
  output logic [P_A_WIDTH-1:0]   out_addr,
  output logic                   out_corr,
  output logic                   out_uncorr,
`ifdef BCH_DEC_SCRUB_EN
  output logic                   scrub_valid,
  input  logic                   scrub_ready,
  output logic [P_D_WIDTH-1:0]   scrub_d,
  output logic [P_A_WIDTH-1:0]   scrub_addr,
  output logic                   scrub_ovf,
`endif
  input  logic                   cnt_clr,
  output logic [P_CNT_WIDTH-1:0] corr_cnt,
  output logic [P_CNT_WIDTH-1:0] uncorr_cnt
);

  localparam logic [P_CNT_WIDTH-1:0] CNT_SAT = SAT_ALL_ONES[P_CNT_WIDTH-1:0];

  logic                 s1_valid;
  logic [P_D_WIDTH-1:0] s1_d;
  logic [P_E_WIDTH-1:0] s1_ecc;
  logic [P_A_WIDTH-1:0] s1_addr;
  logic [P_D_WIDTH-1:0] msk;
  logic                 err_det;
  logic [P_D_WIDTH-1:0] corr_d;
  logic                 dec_corr;
  logic                 dec_uncorr;
  logic                 s2_load;
  logic                 accept;

  bch_dec_dcd_univ_top #(
    .D_WIDTH (P_D_WIDTH),
    .E_WIDTH (P_E_WIDTH)
  ) u_dcd (
    .d       (s1_d),
    .ecc     (s1_ecc),
    .msk     (msk),
    .err_det (err_det)
  );

  assign corr_d     = s1_d ^ msk;
  assign dec_corr   = err_det && (|msk);
  assign dec_uncorr = err_det && !(|msk);

  // in_ready depends only on pipeline state and out_ready, never in_valid.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_ecc   <= '0;
      s1_addr  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_d     <= in_d;
      s1_ecc   <= in_ecc;
      s1_addr  <= in_addr;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_d      <= '0;
      out_addr   <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      out_d      <= corr_d;
      out_addr   <= s1_addr;
      out_corr   <= dec_corr;
      out_uncorr <= dec_uncorr;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (s2_load) begin
      if (dec_corr && corr_cnt != CNT_SAT)
        corr_cnt <= corr_cnt + P_CNT_WIDTH'(1);
      if (dec_uncorr && uncorr_cnt != CNT_SAT)
        uncorr_cnt <= uncorr_cnt + P_CNT_WIDTH'(1);
    end
  end

`ifdef BCH_DEC_SCRUB_EN
  logic scrub_req;
  logic scrub_busy;

  assign scrub_req  = s2_load && dec_corr;
  // Busy only if the pending request is not draining this cycle; a request
  // completing alongside a new one lets the new one load.
  assign scrub_busy = scrub_valid && !scrub_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrub_valid <= 1'b0;
      scrub_d     <= '0;
      scrub_addr  <= '0;
      scrub_ovf   <= 1'b0;
    end else begin
      if (scrub_req && !scrub_busy) begin
        scrub_valid <= 1'b1;
        scrub_d     <= corr_d;
        scrub_addr  <= s1_addr;
      end else if (scrub_valid && scrub_ready) begin
        scrub_valid <= 1'b0;
      end
      if (cnt_clr)
        scrub_ovf <= 1'b0;
      else if (scrub_req && scrub_busy)
        scrub_ovf <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bch_dec_rd_corr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bch_dec_rd_corr
// Description : Scoreboard bench for bch_dec_rd_corr. Words are built from
//               a clean random value, encoded with a positional SEC-DED
//               model, then corrupted by a chosen error class; the
//               expected output follows from the error class alone.
//               Scrub checks are compiled in with BCH_DEC_SCRUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bch_dec_rd_corr;

  localparam int DW = 32;
  localparam int EW = 7;
  localparam int M  = 6;
  localparam int AW = 16;
  localparam int CW = 4;
  localparam int CMAX = 15;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          corr;
    logic          uncorr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_d;
  logic [EW-1:0] in_ecc;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_d;
  logic [AW-1:0] out_addr;
  logic          out_corr;
  logic          out_uncorr;
  logic          cnt_clr;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;
`ifdef BCH_DEC_SCRUB_EN
  logic          scrub_valid;
  logic          scrub_ready;
  logic [DW-1:0] scrub_d;
  logic [AW-1:0] scrub_addr;
  logic          scrub_ovf;
`endif

  always #5 clk = ~clk;

  bch_dec_rd_corr #(
    .P_D_WIDTH   (DW),
    .P_A_WIDTH   (AW),
    .P_CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_d        (in_d),
    .in_ecc      (in_ecc),
    .in_addr     (in_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_d       (out_d),
    .out_addr    (out_addr),
    .out_corr    (out_corr),
    .out_uncorr  (out_uncorr),
`ifdef BCH_DEC_SCRUB_EN
    .scrub_valid (scrub_valid),
    .scrub_ready (scrub_ready),
    .scrub_d     (scrub_d),
    .scrub_addr  (scrub_addr),
    .scrub_ovf   (scrub_ovf),
`endif
    .cnt_clr     (cnt_clr),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt)
  );

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pos[DW];
  int   exp_corr = 0;
  int   exp_uncorr = 0;
  int   accepted = 0;
  bit   rand_bp = 0;
  bit   held = 0;
  exp_t held_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Codeword positions: data bit i takes the i-th position >= 3 that has
  // more than one bit set; single-bit positions belong to the check bits.
  task automatic build_pos();
    int n = 0;
    for (int p = 3; n < DW; p++) begin
      if ($countones(p) != 1) begin
        pos[n] = p;
        n++;
      end
    end
  endtask

  function automatic logic [EW-1:0] encode(input logic [DW-1:0] d);
    logic [M-1:0] c = '0;
    for (int i = 0; i < DW; i++)
      for (int j = 0; j < M; j++)
        if (d[i] && ((pos[i] >> j) & 1) == 1) c[j] = ~c[j];
    return {(^d) ^ (^c), c};
  endfunction

  // kind: 0 clean, 1 one data bit, 2 one check bit, 3 two distinct bits
  task automatic make_word(input int kind, input logic [DW-1:0] clean, input logic [AW-1:0] a,
                           output logic [DW-1:0] d, output logic [EW-1:0] e, output exp_t ex);
    logic [DW+EW-1:0] cw;
    int b0, b1;
    cw = {encode(clean), clean};
    ex.d = clean; ex.a = a; ex.corr = 1'b0; ex.uncorr = 1'b0;
    case (kind)
      1: begin cw[$urandom_range(0, DW-1)] ^= 1'b1; ex.corr = 1'b1; end
      2: cw[$urandom_range(DW, DW+EW-1)] ^= 1'b1;
      3: begin
        b0 = $urandom_range(0, DW+EW-1);
        do b1 = $urandom_range(0, DW+EW-1); while (b1 == b0);
        cw[b0] ^= 1'b1; cw[b1] ^= 1'b1;
        ex.d = cw[DW-1:0]; ex.uncorr = 1'b1;
      end
      default: ;
    endcase
    d = cw[DW-1:0];
    e = cw[DW+EW-1:DW];
  endtask

  // Present one word; returns #1 after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic [EW-1:0] e, input exp_t ex);
    bit got = 0;
    in_valid = 1'b1; in_d = d; in_ecc = e; in_addr = ex.a;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ex);
        accepted++;
        if (ex.corr && exp_corr < CMAX) exp_corr++;
        if (ex.uncorr && exp_uncorr < CMAX) exp_uncorr++;
        got = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_kind(input int kind, input logic [DW-1:0] clean, input logic [AW-1:0] a);
    logic [DW-1:0] d; logic [EW-1:0] e; exp_t ex;
    make_word(kind, clean, a, d, e, ex);
    send(d, e, ex);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
  endtask

  // Monitor: compare on every output handshake; while stalled, payload must
  // not move.
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else if (out_valid) begin
      if (held) chk("stall_stable", {out_d, out_addr, out_corr, out_uncorr}, held_val);
      if (out_ready) begin
        held = 0;
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t ex;
          ex = sb.pop_front();
          chk("out_word", {out_d, out_addr, out_corr, out_uncorr}, ex);
        end
      end else begin
        held = 1;
        held_val = {out_d, out_addr, out_corr, out_uncorr};
      end
    end else begin
      held = 0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    exp_t ex;
    int base;

    build_pos();
    rst = 1'b1; in_valid = 1'b0; in_d = '0; in_ecc = '0; in_addr = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
`ifdef BCH_DEC_SCRUB_EN
    scrub_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_payload", {out_d, out_addr, out_corr, out_uncorr}, 0);
    chk("rst_counters", {corr_cnt, uncorr_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean word: driven after edge K, captured at K+1, presented after K+2.
    ex.d = 32'hDEADBEEF; ex.a = 16'h00A5; ex.corr = 1'b0; ex.uncorr = 1'b0;
    in_valid = 1'b1; in_d = 32'hDEADBEEF; in_ecc = encode(32'hDEADBEEF); in_addr = 16'h00A5;
    @(negedge clk);
    chk("first_in_ready", in_ready, 1);
    sb.push_back(ex); accepted++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_early", out_valid, 0);
    @(negedge clk);
    chk("latency_two", out_valid, 1);
    wait_drain();

    // Single-bit flip of bit 5.
    d = 32'hDEADBEEF ^ 32'h20;
    ex.d = 32'hDEADBEEF; ex.a = 16'h1111; ex.corr = 1'b1; ex.uncorr = 1'b0;
    send(d, encode(32'hDEADBEEF), ex);
    wait_drain();
`ifdef BCH_DEC_SCRUB_EN
    chk("scrub_ovf_idle", scrub_ovf, 0);
`endif
    // Double data flip: uncorrectable, raw data passes through.
    d = 32'hDEADBEEF ^ 32'h3;
    ex.d = d; ex.a = 16'h2222; ex.corr = 1'b0; ex.uncorr = 1'b1;
    send(d, encode(32'hDEADBEEF), ex);
    wait_drain();
    chk("corr_cnt_one", corr_cnt, exp_corr);
    chk("uncorr_cnt_one", uncorr_cnt, exp_uncorr);

    // Saturation: 2^CW + 2 corrected words.
    pulse_clr();
    for (int i = 0; i < (1 << CW) + 2; i++) send_kind(1, $urandom, 16'(i));
    wait_drain();
    chk("corr_cnt_sat", corr_cnt, CMAX);
    chk("corr_cnt_sat_model", exp_corr, CMAX);

    // Clear lands on the same edge as an increment.
    send_kind(1, $urandom, 16'h3333);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    wait_drain();
    chk("clr_vs_inc", {corr_cnt, uncorr_cnt}, 0);

    // Backpressure: 4-word stream against a 5-cycle stall.
    out_ready = 1'b0;
    base = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++) send_kind(i, $urandom, 16'h4000 + 16'(i));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepts", accepted - base, 2);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Randomized stream with random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 200; i++) begin
      send_kind($urandom_range(0, 3), $urandom, 16'($urandom));
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    rand_bp = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();
    chk("corr_cnt_rand", corr_cnt, exp_corr);
    chk("uncorr_cnt_rand", uncorr_cnt, exp_uncorr);

`ifdef BCH_DEC_SCRUB_EN
    // Scrub overflow: two corrected words while the consumer is stalled.
    scrub_ready = 1'b0;
    @(posedge clk); #1;
    chk("scrub_empty", scrub_valid, 0);
    d = 32'hDEADBEEF ^ 32'h20;
    ex.d = 32'hDEADBEEF; ex.a = 16'h5A5A; ex.corr = 1'b1; ex.uncorr = 1'b0;
    send(d, encode(32'hDEADBEEF), ex);
    send_kind(1, 32'h12345678, 16'h6B6B);
    wait_drain();
    chk("scrub_valid", scrub_valid, 1);
    chk("scrub_d", scrub_d, 32'hDEADBEEF);
    chk("scrub_addr", scrub_addr, 16'h5A5A);
    chk("scrub_ovf", scrub_ovf, 1);
    scrub_ready = 1'b1;
    @(posedge clk); #1;
    chk("scrub_done", scrub_valid, 0);
    pulse_clr();
    chk("scrub_ovf_clr", scrub_ovf, 0);
`endif

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send_kind(1, $urandom, 16'h7001);
    send_kind(1, $urandom, 16'h7002);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_counters", {corr_cnt, uncorr_cnt}, 0);
`ifdef BCH_DEC_SCRUB_EN
    chk("arst_scrub_valid", scrub_valid, 0);
`endif
    sb.delete();
    exp_corr = 0; exp_uncorr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_quiet", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
